// File: rtl/axi_lite_master_if.sv
// AXI4-Lite bus bundle between a single master and a single slave.
//   master modport: drives AW/W/AR requests and B/R ready, samples the rest.
//   slave modport : mirror image, used by slave models and monitors.
interface axi_lite_master_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] AWADDR;
  logic              AWVALID;
  logic              AWREADY;
  logic [DATA_W-1:0] WDATA;
  logic              WVALID;
  logic              WREADY;
  logic [1:0]        BRESP;
  logic              BVALID;
  logic              BREADY;
  logic [ADDR_W-1:0] ARADDR;
  logic              ARVALID;
  logic              ARREADY;
  logic [DATA_W-1:0] RDATA;
  logic [1:0]        RRESP;
  logic              RVALID;
  logic              RREADY;

  modport master (
    output AWADDR, AWVALID, WDATA, WVALID, BREADY, ARADDR, ARVALID, RREADY,
    input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
  );

  modport slave (
    input  AWADDR, AWVALID, WDATA, WVALID, BREADY, ARADDR, ARVALID, RREADY,
    output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
  );
endinterface

// File: rtl/axi_lite_master.sv
// Single-outstanding AXI4-Lite master. Turns one command (read or write)
// into the matching AXI transaction and reports the result with a
// one-cycle completion strobe.
//   ACLK, ARESETn           : clock, synchronous active-low reset
//   cmd_valid/cmd_ready     : command handshake (ready only when idle)
//   cmd_write/addr/wdata    : command contents, latched on acceptance
//   rsp_valid/rdata/resp    : completion strobe, read data (0 for writes), BRESP/RRESP
//   axi                     : AXI4-Lite master port
//
// state   | meaning
// --------+---------------------------------------------------------
// IDLE    | cmd_ready high, waiting for a command
// WR_REQ  | AW and W offered; each drops after its own handshake
// WR_RESP | BREADY high, waiting for BVALID
// RD_REQ  | ARVALID high, waiting for ARREADY
// RD_DATA | RREADY high, waiting for RVALID
// RSP     | rsp_valid high for one cycle
module axi_lite_master #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32
) (
  input  logic              ACLK,
  input  logic              ARESETn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [1:0]        rsp_resp,
  axi_lite_master_if.master axi
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_REQ  = 3'd1,
    WR_RESP = 3'd2,
    RD_REQ  = 3'd3,
    RD_DATA = 3'd4,
    RSP     = 3'd5
  } state_t;

  state_t            state_q;
  logic              cmd_ready_q;
  logic              awvalid_q;
  logic              wvalid_q;
  logic              arvalid_q;
  logic              bready_q;
  logic              rready_q;
  logic              rsp_valid_q;
  logic [ADDR_W-1:0] awaddr_q;
  logic [ADDR_W-1:0] araddr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rsp_rdata_q;
  logic [1:0]        rsp_resp_q;

  // A channel counts as done once its VALID has already dropped or it is
  // handshaking now; this covers AW/W completing together or in either order.
  logic aw_done, w_done;
  assign aw_done = !awvalid_q || axi.AWREADY;
  assign w_done  = !wvalid_q  || axi.WREADY;

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      state_q     <= IDLE;
      cmd_ready_q <= 1'b1;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      bready_q    <= 1'b0;
      rready_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      awaddr_q    <= '0;
      araddr_q    <= '0;
      wdata_q     <= '0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cmd_valid) begin
            cmd_ready_q <= 1'b0;
            if (cmd_write) begin
              awaddr_q  <= cmd_addr;
              wdata_q   <= cmd_wdata;
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
              state_q   <= WR_REQ;
            end else begin
              araddr_q  <= cmd_addr;
              arvalid_q <= 1'b1;
              state_q   <= RD_REQ;
            end
          end
        end
        WR_REQ: begin
          if (awvalid_q && axi.AWREADY) awvalid_q <= 1'b0;
          if (wvalid_q && axi.WREADY)   wvalid_q  <= 1'b0;
          if (aw_done && w_done) begin
            bready_q <= 1'b1;
            state_q  <= WR_RESP;
          end
        end
        WR_RESP: begin
          if (axi.BVALID) begin
            bready_q    <= 1'b0;
            rsp_resp_q  <= axi.BRESP;
            rsp_rdata_q <= '0;
            rsp_valid_q <= 1'b1;
            state_q     <= RSP;
          end
        end
        RD_REQ: begin
          if (axi.ARREADY) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (axi.RVALID) begin
            rready_q    <= 1'b0;
            rsp_rdata_q <= axi.RDATA;
            rsp_resp_q  <= axi.RRESP;
            rsp_valid_q <= 1'b1;
            state_q     <= RSP;
          end
        end
        RSP: begin
          rsp_valid_q <= 1'b0;
          cmd_ready_q <= 1'b1;
          state_q     <= IDLE;
        end
        default: begin
          awvalid_q   <= 1'b0;
          wvalid_q    <= 1'b0;
          arvalid_q   <= 1'b0;
          bready_q    <= 1'b0;
          rready_q    <= 1'b0;
          rsp_valid_q <= 1'b0;
          cmd_ready_q <= 1'b1;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign cmd_ready   = cmd_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_resp    = rsp_resp_q;
  assign axi.AWADDR  = awaddr_q;
  assign axi.AWVALID = awvalid_q;
  assign axi.WDATA   = wdata_q;
  assign axi.WVALID  = wvalid_q;
  assign axi.BREADY  = bready_q;
  assign axi.ARADDR  = araddr_q;
  assign axi.ARVALID = arvalid_q;
  assign axi.RREADY  = rready_q;

endmodule

// File: tb/tb_axi_lite_master.sv
module tb_axi_lite_master;
  localparam int AW = 4;
  localparam int DW = 32;

  logic          ACLK = 1'b0;
  logic          ARESETn = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic          cmd_ready;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic [1:0]    rsp_resp;

  axi_lite_master_if #(.ADDR_W(AW), .DATA_W(DW)) axi ();

  axi_lite_master #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .axi(axi)
  );

  always #5 ACLK = ~ACLK;

  int errors = 0;
  int checks = 0;

  // slave knobs and memories (slave's own storage vs. the reference model)
  int          aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
  logic [1:0]  b_resp = 2'd0, r_resp = 2'd0;
  logic [31:0] slv_mem [0:3];
  logic [31:0] ref_mem [0:3];

  // monitor results
  int            aw_hs = 0, w_hs = 0, ar_hs = 0, rsp_cnt = 0, viol = 0;
  logic [AW-1:0] last_awaddr = '0;
  logic [DW-1:0] last_wdata = '0;
  logic [AW-1:0] last_araddr = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Behavioural AXI-Lite slave with per-channel programmable latency.
  initial begin
    int aw_wait, w_wait, b_wait, ar_wait, r_wait;
    bit aw_got, w_got, ar_got, b_fire, r_fire;
    logic [AW-1:0] aw_lat, ar_lat;
    logic [DW-1:0] w_lat;
    axi.AWREADY = 0; axi.WREADY = 0; axi.BVALID = 0; axi.BRESP = 0;
    axi.ARREADY = 0; axi.RVALID = 0; axi.RDATA = 0; axi.RRESP = 0;
    aw_wait = 0; w_wait = 0; b_wait = 0; ar_wait = 0; r_wait = 0;
    aw_got = 0; w_got = 0; ar_got = 0; b_fire = 0; r_fire = 0;
    aw_lat = '0; ar_lat = '0; w_lat = '0;
    forever begin
      @(posedge ACLK); #1;
      if (!ARESETn) begin
        axi.AWREADY = 0; axi.WREADY = 0; axi.BVALID = 0; axi.ARREADY = 0; axi.RVALID = 0;
        aw_wait = 0; w_wait = 0; b_wait = 0; ar_wait = 0; r_wait = 0;
        aw_got = 0; w_got = 0; ar_got = 0; b_fire = 0; r_fire = 0;
      end else begin
        if (axi.AWREADY) begin axi.AWREADY = 0; aw_got = 1; aw_wait = 0; end
        else if (axi.AWVALID) begin
          if (aw_wait >= aw_dly) begin axi.AWREADY = 1; aw_lat = axi.AWADDR; end
          else aw_wait++;
        end
        if (axi.WREADY) begin axi.WREADY = 0; w_got = 1; w_wait = 0; end
        else if (axi.WVALID) begin
          if (w_wait >= w_dly) begin axi.WREADY = 1; w_lat = axi.WDATA; end
          else w_wait++;
        end
        if (axi.BVALID && b_fire) axi.BVALID = 0;
        else if (aw_got && w_got && !axi.BVALID) begin
          if (b_wait >= b_dly) begin
            axi.BVALID = 1; axi.BRESP = b_resp;
            slv_mem[aw_lat[3:2]] = w_lat;
            aw_got = 0; w_got = 0; b_wait = 0;
          end else b_wait++;
        end
        if (axi.ARREADY) begin axi.ARREADY = 0; ar_got = 1; ar_wait = 0; end
        else if (axi.ARVALID) begin
          if (ar_wait >= ar_dly) begin axi.ARREADY = 1; ar_lat = axi.ARADDR; end
          else ar_wait++;
        end
        if (axi.RVALID && r_fire) axi.RVALID = 0;
        else if (ar_got && !axi.RVALID) begin
          if (r_wait >= r_dly) begin
            axi.RVALID = 1; axi.RDATA = slv_mem[ar_lat[3:2]]; axi.RRESP = r_resp;
            ar_got = 0; r_wait = 0;
          end else r_wait++;
        end
        b_fire = axi.BVALID && axi.BREADY;
        r_fire = axi.RVALID && axi.RREADY;
      end
    end
  end

  // Protocol monitor: handshake counts, VALID/payload stability, drop-after-handshake.
  initial begin
    bit p_rst, p_awv, p_awr, p_wv, p_wr, p_arv, p_arr;
    logic [AW-1:0] p_awa, p_ara;
    logic [DW-1:0] p_wd;
    p_rst = 0; p_awv = 0; p_awr = 0; p_wv = 0; p_wr = 0; p_arv = 0; p_arr = 0;
    p_awa = '0; p_ara = '0; p_wd = '0;
    forever begin
      @(posedge ACLK);
      if (p_rst) begin
        if (p_awv && p_awr && axi.AWVALID) viol++;
        if (p_awv && !p_awr && (!axi.AWVALID || axi.AWADDR !== p_awa)) viol++;
        if (p_wv && p_wr && axi.WVALID) viol++;
        if (p_wv && !p_wr && (!axi.WVALID || axi.WDATA !== p_wd)) viol++;
        if (p_arv && p_arr && axi.ARVALID) viol++;
        if (p_arv && !p_arr && (!axi.ARVALID || axi.ARADDR !== p_ara)) viol++;
      end
      if (ARESETn) begin
        if (axi.AWVALID && axi.AWREADY) begin aw_hs++; last_awaddr = axi.AWADDR; end
        if (axi.WVALID && axi.WREADY) begin w_hs++; last_wdata = axi.WDATA; end
        if (axi.ARVALID && axi.ARREADY) begin ar_hs++; last_araddr = axi.ARADDR; end
        if (rsp_valid) rsp_cnt++;
      end
      p_awv = axi.AWVALID; p_awr = axi.AWREADY; p_awa = axi.AWADDR;
      p_wv = axi.WVALID; p_wr = axi.WREADY; p_wd = axi.WDATA;
      p_arv = axi.ARVALID; p_arr = axi.ARREADY; p_ara = axi.ARADDR;
      p_rst = ARESETn;
    end
  end

  logic [DW-1:0] t_rd;
  logic [1:0]    t_rs;
  bit            t_done, t_busy, t_one;

  task automatic run_cmd(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         output logic [DW-1:0] rd, output logic [1:0] rs,
                         output bit done, output bit rdy_busy, output bit one_cycle);
    int n;
    rd = '0; rs = '0; done = 0; rdy_busy = 0; one_cycle = 0;
    @(negedge ACLK);
    cmd_valid = 1; cmd_write = wr; cmd_addr = a; cmd_wdata = d;
    n = 0;
    while (!cmd_ready && n < 100) begin @(negedge ACLK); n++; end
    @(negedge ACLK);
    cmd_valid = 0;
    for (int k = 0; k < 300; k++) begin
      if (rsp_valid) begin done = 1; rd = rsp_rdata; rs = rsp_resp; break; end
      if (cmd_ready) rdy_busy = 1;
      @(negedge ACLK);
    end
    if (done) begin @(negedge ACLK); one_cycle = !rsp_valid; end
  endtask

  initial begin
    int a0, w0, r0, c0, exp_aw, exp_w, exp_ar;
    bit wr;
    int idx;
    logic [DW-1:0] dat, exp_rd;
    logic [1:0] exp_rs;
    for (int i = 0; i < 4; i++) begin slv_mem[i] = 32'h0; ref_mem[i] = 32'h0; end

    // reset
    ARESETn = 0;
    repeat (3) @(negedge ACLK);
    check("reset_outputs", 64'({axi.AWVALID, axi.WVALID, axi.ARVALID, axi.BREADY, axi.RREADY, rsp_valid}), 64'd0);
    check("reset_payload", 64'({axi.AWADDR, axi.ARADDR, axi.WDATA, rsp_resp}), 64'd0);
    check("reset_rsp_rdata", 64'(rsp_rdata), 64'd0);
    ARESETn = 1;
    @(negedge ACLK);
    check("cmd_ready_after_reset", 64'(cmd_ready), 64'd1);

    // write, AW and W ready together, B two cycles later
    aw_dly = 0; w_dly = 0; b_dly = 2; b_resp = 2'd0;
    a0 = aw_hs; w0 = w_hs; r0 = rsp_cnt;
    run_cmd(1'b1, 4'h4, 32'hDEADBEEF, t_rd, t_rs, t_done, t_busy, t_one);
    ref_mem[1] = 32'hDEADBEEF;
    check("wr1_done", 64'(t_done), 64'd1);
    check("wr1_rdata", 64'(t_rd), 64'd0);
    check("wr1_resp", 64'(t_rs), 64'd0);
    check("wr1_one_cycle", 64'(t_one), 64'd1);
    check("wr1_aw_count", 64'(aw_hs - a0), 64'd1);
    check("wr1_w_count", 64'(w_hs - w0), 64'd1);
    check("wr1_awaddr", 64'(last_awaddr), 64'h4);
    check("wr1_wdata", 64'(last_wdata), 64'hDEADBEEF);
    check("wr1_rsp_count", 64'(rsp_cnt - r0), 64'd1);

    // write, W accepted 3 cycles before AW
    aw_dly = 3; w_dly = 0; b_dly = 0; b_resp = 2'd0;
    a0 = aw_hs; w0 = w_hs; r0 = rsp_cnt;
    run_cmd(1'b1, 4'h8, 32'h0BADF00D, t_rd, t_rs, t_done, t_busy, t_one);
    ref_mem[2] = 32'h0BADF00D;
    check("wr2_done", 64'(t_done), 64'd1);
    check("wr2_awaddr", 64'(last_awaddr), 64'h8);
    check("wr2_aw_count", 64'(aw_hs - a0), 64'd1);
    check("wr2_w_count", 64'(w_hs - w0), 64'd1);
    check("wr2_rsp_count", 64'(rsp_cnt - r0), 64'd1);

    // read with RRESP=2
    slv_mem[3] = 32'h12345678; ref_mem[3] = 32'h12345678;
    aw_dly = 0; ar_dly = 1; r_dly = 2; r_resp = 2'd2;
    a0 = ar_hs;
    run_cmd(1'b0, 4'hC, 32'h0, t_rd, t_rs, t_done, t_busy, t_one);
    check("rd1_done", 64'(t_done), 64'd1);
    check("rd1_rdata", 64'(t_rd), 64'h12345678);
    check("rd1_resp", 64'(t_rs), 64'd2);
    check("rd1_one_cycle", 64'(t_one), 64'd1);
    check("rd1_araddr", 64'(last_araddr), 64'hC);
    check("rd1_ar_count", 64'(ar_hs - a0), 64'd1);

    // write then read back, cmd_ready must stay low while busy
    ar_dly = 0; r_dly = 0; r_resp = 2'd0;
    run_cmd(1'b1, 4'h0, 32'hA5A5A5A5, t_rd, t_rs, t_done, t_busy, t_one);
    ref_mem[0] = 32'hA5A5A5A5;
    check("wr3_busy_ready", 64'(t_busy), 64'd0);
    run_cmd(1'b0, 4'h0, 32'h0, t_rd, t_rs, t_done, t_busy, t_one);
    check("rd3_busy_ready", 64'(t_busy), 64'd0);
    check("rd3_rdata", 64'(t_rd), 64'hA5A5A5A5);
    check("rd3_resp", 64'(t_rs), 64'd0);

    // reset while stuck in WR_REQ
    aw_dly = 100000; w_dly = 0;
    @(negedge ACLK);
    cmd_valid = 1; cmd_write = 1; cmd_addr = 4'h4; cmd_wdata = 32'h11112222;
    @(negedge ACLK);
    cmd_valid = 0;
    repeat (3) @(negedge ACLK);
    check("abort_awvalid_held", 64'(axi.AWVALID), 64'd1);
    r0 = rsp_cnt;
    ARESETn = 0;
    @(negedge ACLK);
    check("abort_valids_low", 64'({axi.AWVALID, axi.WVALID, axi.ARVALID, axi.BREADY, axi.RREADY, rsp_valid}), 64'd0);
    ARESETn = 1; aw_dly = 0;
    repeat (4) @(negedge ACLK);
    check("abort_no_rsp", 64'(rsp_cnt - r0), 64'd0);
    run_cmd(1'b0, 4'h4, 32'h0, t_rd, t_rs, t_done, t_busy, t_one);
    check("abort_read_done", 64'(t_done), 64'd1);
    check("abort_read_rdata", 64'(t_rd), 64'(ref_mem[1]));

    // stray cmd_valid pulse while waiting for read data
    ar_dly = 0; r_dly = 6;
    a0 = ar_hs; w0 = aw_hs; r0 = rsp_cnt;
    fork
      run_cmd(1'b0, 4'h8, 32'h0, t_rd, t_rs, t_done, t_busy, t_one);
      begin
        int n;
        n = 0;
        while (!axi.RREADY && n < 60) begin @(negedge ACLK); n++; end
        cmd_valid = 1; cmd_write = 1; cmd_addr = 4'h8; cmd_wdata = 32'hBAD0BAD0;
        @(negedge ACLK);
        cmd_valid = 0;
      end
    join
    repeat (4) @(negedge ACLK);
    check("busy_cmd_rdata", 64'(t_rd), 64'(ref_mem[2]));
    check("busy_cmd_ar_count", 64'(ar_hs - a0), 64'd1);
    check("busy_cmd_aw_count", 64'(aw_hs - w0), 64'd0);
    check("busy_cmd_rsp_count", 64'(rsp_cnt - r0), 64'd1);

    // randomized traffic against the memory reference model
    exp_aw = aw_hs; exp_w = w_hs; exp_ar = ar_hs; c0 = rsp_cnt;
    for (int t = 0; t < 40; t++) begin
      wr = 1'($urandom_range(0, 1));
      idx = int'($urandom_range(0, 3));
      dat = $urandom;
      aw_dly = int'($urandom_range(0, 3)); w_dly = int'($urandom_range(0, 3));
      b_dly = int'($urandom_range(0, 3)); ar_dly = int'($urandom_range(0, 3));
      r_dly = int'($urandom_range(0, 3));
      b_resp = 2'($urandom_range(0, 3)); r_resp = 2'($urandom_range(0, 3));
      if (wr) begin
        ref_mem[idx] = dat; exp_rd = '0; exp_rs = b_resp; exp_aw++; exp_w++;
      end else begin
        exp_rd = ref_mem[idx]; exp_rs = r_resp; exp_ar++;
      end
      run_cmd(wr, 4'(idx * 4), dat, t_rd, t_rs, t_done, t_busy, t_one);
      check("rand_done", 64'(t_done), 64'd1);
      check("rand_rdata", 64'(t_rd), 64'(exp_rd));
      check("rand_resp", 64'(t_rs), 64'(exp_rs));
    end
    check("rand_aw_total", 64'(aw_hs), 64'(exp_aw));
    check("rand_w_total", 64'(w_hs), 64'(exp_w));
    check("rand_ar_total", 64'(ar_hs), 64'(exp_ar));
    check("rand_rsp_total", 64'(rsp_cnt - c0), 64'd40);
    check("protocol_violations", 64'(viol), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
